// File: rtl/cmd_req_arbiter.sv
// -----------------------------------------------------------------------------
// cmd_req_arbiter
//   Shares one command-generator channel between g_num_req requesters using a
//   round-robin arbiter. For each transaction the winner's command word is
//   latched and shifted out MSB-first on data_out/strobe_out. The block then
//   waits for a rising edge on stage4_in, or for a timeout, and reports
//   completion to the winner.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   req          level request per requester, held until gnt
//   req_data     command words, requester i at [i*W +: W]
//   gnt          one-hot pulse in the ARB cycle: word accepted
//   done         one-hot pulse in the DONE cycle: transaction finished
//   timeout_err  pulses with done when the transaction timed out
//   data_out     serial command bit to the generator
//   strobe_out   high while data_out carries a valid bit
//   stage4_in    completion indication from the generator
//   busy         high in every state except IDLE
// -----------------------------------------------------------------------------
module cmd_req_arbiter #(
  parameter int g_num_req    = 4,
  parameter int g_word_width = 8,
  parameter int g_timeout    = 1024
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [g_num_req-1:0]                req,
  input  logic [g_num_req*g_word_width-1:0]   req_data,
  output logic [g_num_req-1:0]                gnt,
  output logic [g_num_req-1:0]                done,
  output logic                                timeout_err,
  output logic                                data_out,
  output logic                                strobe_out,
  input  logic                                stage4_in,
  output logic                                busy
);

  localparam int IDX_W = $clog2(g_num_req);
  localparam int BIT_W = (g_word_width > 1) ? $clog2(g_word_width) : 1;
  localparam int TO_W  = $clog2(g_timeout + 1);

  typedef enum logic [2:0] {IDLE, ARB, SHIFT, WAIT, DONE} state_t;

  state_t                  state_reg;
  logic [IDX_W-1:0]        ptr_reg;
  logic [IDX_W-1:0]        idx_reg;
  logic [g_word_width-1:0] shift_reg;
  logic [BIT_W-1:0]        bit_cnt_reg;
  logic [TO_W-1:0]         to_cnt_reg;
  logic                    to_flag_reg;
  logic                    s4_prev_reg;

  // Round-robin search. cand_idx[k] is the requester checked at priority k,
  // counting upward from ptr and wrapping.
  logic [IDX_W-1:0] cand_idx [g_num_req];
  logic [g_num_req-1:0] cand_req;
  logic             win_found;
  logic [IDX_W-1:0] win_idx;

  genvar gi;
  generate
    for (gi = 0; gi < g_num_req; gi++) begin : g_cand
      assign cand_idx[gi] = IDX_W'((int'(ptr_reg) + gi) % g_num_req);
      assign cand_req[gi] = req[cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    win_idx = '0;
    // Descending scan so the lowest priority slot (closest to ptr) wins.
    for (int k = g_num_req - 1; k >= 0; k--) begin
      if (cand_req[k]) win_idx = cand_idx[k];
    end
    win_found = |req;
  end

  // Completion is a rising edge only. A level already high when WAIT is
  // entered does not count, because s4_prev_reg tracks stage4_in in all states.
  logic s4_edge;
  assign s4_edge = stage4_in & ~s4_prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      ptr_reg     <= '0;
      idx_reg     <= '0;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      to_cnt_reg  <= '0;
      to_flag_reg <= 1'b0;
      s4_prev_reg <= 1'b0;
    end else begin
      s4_prev_reg <= stage4_in;
      case (state_reg)
        IDLE: begin
          if (|req) state_reg <= ARB;
        end
        ARB: begin
          if (win_found) begin
            idx_reg     <= win_idx;
            shift_reg   <= req_data[win_idx*g_word_width +: g_word_width];
            bit_cnt_reg <= '0;
            state_reg   <= SHIFT;
          end else begin
            state_reg   <= IDLE;
          end
        end
        SHIFT: begin
          shift_reg <= shift_reg << 1;
          if (bit_cnt_reg == BIT_W'(g_word_width - 1)) begin
            to_cnt_reg <= '0;
            state_reg  <= WAIT;
          end else begin
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
          end
        end
        WAIT: begin
          to_cnt_reg <= to_cnt_reg + 1'b1;
          // The edge is checked first so that it wins a tie with the timeout.
          if (s4_edge) begin
            state_reg <= DONE;
          end else if (to_cnt_reg == TO_W'(g_timeout - 1)) begin
            to_flag_reg <= 1'b1;
            state_reg   <= DONE;
          end
        end
        DONE: begin
          ptr_reg     <= (idx_reg == IDX_W'(g_num_req - 1)) ? '0 : idx_reg + 1'b1;
          to_flag_reg <= 1'b0;
          to_cnt_reg  <= '0;
          state_reg   <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Outputs are decodes of registered state. gnt is the exception: it has to
  // appear in the ARB cycle itself, so it also depends on the live req.
  generate
    for (gi = 0; gi < g_num_req; gi++) begin : g_out
      assign gnt[gi]  = (state_reg == ARB) && win_found && (win_idx == IDX_W'(gi));
      assign done[gi] = (state_reg == DONE) && (idx_reg == IDX_W'(gi));
    end
  endgenerate

  assign timeout_err = (state_reg == DONE) && to_flag_reg;
  assign strobe_out  = (state_reg == SHIFT);
  assign data_out    = (state_reg == SHIFT) && shift_reg[g_word_width-1];
  assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_cmd_req_arbiter.sv
// Directed bench for cmd_req_arbiter (4 requesters, 8-bit words, timeout 16).
// Inputs change at the falling edge and outputs are checked at the falling edge.
module tb_cmd_req_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        timeout_err;
  logic        data_out;
  logic        strobe_out;
  logic        stage4_in;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  cmd_req_arbiter #(
    .g_num_req   (4),
    .g_word_width(8),
    .g_timeout   (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_data   (req_data),
    .gnt        (gnt),
    .done       (done),
    .timeout_err(timeout_err),
    .data_out   (data_out),
    .strobe_out (strobe_out),
    .stage4_in  (stage4_in),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  // Checks the eight SHIFT cycles that follow the ARB cycle, MSB first.
  task automatic shift_check(input string tag, input logic [7:0] w);
    for (int i = 7; i >= 0; i--) begin
      next();
      chk({tag, "_stb"}, {31'd0, strobe_out}, 32'd1);
      chk({tag, "_bit"}, {31'd0, data_out}, {31'd0, w[i]});
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = 4'b0000;
    req_data  = 32'h0;
    stage4_in = 1'b0;

    // ---------------- reset state
    next();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_gnt",  {28'd0, gnt}, 32'd0);
    chk("rst_done", {28'd0, done}, 32'd0);
    chk("rst_stb",  {31'd0, strobe_out}, 32'd0);
    chk("rst_data", {31'd0, data_out}, 32'd0);
    chk("rst_terr", {31'd0, timeout_err}, 32'd0);
    rst_n = 1'b1;
    next();

    // ---------------- single request, requester 1 sends A5
    req      = 4'b0010;
    req_data = 32'h0000_A500;
    next();                                    // ARB
    chk("single_gnt",  {28'd0, gnt}, 32'h2);
    chk("single_busy", {31'd0, busy}, 32'd1);
    shift_check("single", 8'hA5);
    req      = 4'b0000;
    req_data = 32'hFFFF_FFFF;                  // ignored after ARB
    for (int k = 0; k < 4; k++) begin          // WAIT cycles 1..4
      next();
      chk("single_wait_stb",  {31'd0, strobe_out}, 32'd0);
      chk("single_wait_data", {31'd0, data_out}, 32'd0);
      chk("single_wait_done", {28'd0, done}, 32'd0);
    end
    next();                                    // 5th cycle after last bit
    stage4_in = 1'b1;
    next();                                    // DONE
    chk("single_done", {28'd0, done}, 32'h2);
    chk("single_terr", {31'd0, timeout_err}, 32'd0);
    stage4_in = 1'b0;
    next();
    chk("single_idle", {31'd0, busy}, 32'd0);

    // ---------------- round-robin from ptr 0
    rst_n = 1'b0;
    next();
    rst_n    = 1'b1;
    req_data = 32'h3C96_5AC3;                  // idx0 C3, idx1 5A, idx2 96, idx3 3C
    req      = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      logic [3:0] exp_g;
      logic [7:0] word;
      exp_g = 4'b0001 << (n % 4);
      word  = req_data[(n % 4)*8 +: 8];
      next();                                  // ARB
      chk("rr_gnt", {28'd0, gnt}, {28'd0, exp_g});
      shift_check("rr", word);
      next();                                  // first WAIT cycle
      chk("rr_wait_stb", {31'd0, strobe_out}, 32'd0);
      stage4_in = 1'b1;
      next();                                  // DONE
      chk("rr_done", {28'd0, done}, {28'd0, exp_g});
      chk("rr_terr", {31'd0, timeout_err}, 32'd0);
      stage4_in = 1'b0;
      next();                                  // IDLE
      chk("rr_idle", {31'd0, busy}, 32'd0);
      if (n == 4) req = 4'b0000;
    end

    // ---------------- timeout: ptr is now 1, only requester 0 asks
    req = 4'b0001;
    next();                                    // ARB
    chk("to_gnt", {28'd0, gnt}, 32'h1);
    shift_check("to", 8'hC3);
    req = 4'b0011;                             // requester 1 joins, 0 keeps asking
    for (int k = 1; k <= 16; k++) begin
      next();
      chk("to_wait_done", {28'd0, done}, 32'd0);
      chk("to_wait_busy", {31'd0, busy}, 32'd1);
    end
    next();                                    // 17th cycle after last bit
    chk("to_done", {28'd0, done}, 32'h1);
    chk("to_terr", {31'd0, timeout_err}, 32'd1);
    next();                                    // IDLE
    chk("to_idle_terr", {31'd0, timeout_err}, 32'd0);
    next();                                    // ARB
    chk("to_next_gnt", {28'd0, gnt}, 32'h2);
    shift_check("to_next", 8'h5A);
    req = 4'b0000;
    next();
    stage4_in = 1'b1;
    next();
    chk("to_next_done", {28'd0, done}, 32'h2);
    chk("to_next_terr", {31'd0, timeout_err}, 32'd0);
    stage4_in = 1'b0;
    next();                                    // IDLE, ptr = 2

    // ---------------- dropped request: req[2] for exactly one cycle
    @(posedge clk);
    #1 req = 4'b0100;
    @(posedge clk);
    #1 req = 4'b0000;                          // gone during ARB
    next();
    chk("drop_busy_arb", {31'd0, busy}, 32'd1);
    chk("drop_gnt", {28'd0, gnt}, 32'd0);
    next();
    chk("drop_idle", {31'd0, busy}, 32'd0);
    chk("drop_stb", {31'd0, strobe_out}, 32'd0);
    // ptr must still be 2: with req 0 and 3 pending, requester 3 wins.
    req = 4'b1001;
    next();
    chk("drop_ptr_gnt", {28'd0, gnt}, 32'h8);

    // ---------------- reset in the middle of SHIFT
    for (int i = 0; i < 3; i++) next();        // bits 1..3 of 3C
    chk("mid_bit3", {31'd0, data_out}, 32'd1);
    req   = 4'b1000;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_data", {31'd0, data_out}, 32'd0);
    chk("mid_rst_stb",  {31'd0, strobe_out}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    next();
    rst_n = 1'b1;
    chk("mid_rst_done", {28'd0, done}, 32'd0);
    next();                                    // ARB
    chk("mid_gnt", {28'd0, gnt}, 32'h8);
    chk("mid_gnt_done", {28'd0, done}, 32'd0);

    // ---------------- stale stage4 level on WAIT entry
    shift_check("stale", 8'h3C);
    req       = 4'b0000;
    stage4_in = 1'b1;                          // already high entering WAIT
    for (int k = 0; k < 4; k++) begin
      next();
      chk("stale_hold_done", {28'd0, done}, 32'd0);
    end
    stage4_in = 1'b0;
    next();
    chk("stale_low_done", {28'd0, done}, 32'd0);
    stage4_in = 1'b1;
    next();
    chk("stale_done", {28'd0, done}, 32'h8);
    chk("stale_terr", {31'd0, timeout_err}, 32'd0);
    stage4_in = 1'b0;
    next();
    chk("stale_idle", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
